// File: rtl/serial_addsub_engine.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a single full adder.
// Optional subtract mode (sub_i port) is enabled by defining SERIAL_ADDSUB_SUB_EN.
module serial_addsub_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDSUB_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_b_cap;
    logic             w_cin_cap;
    logic             w_start_ok;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;

    // Subtraction is A + ~B + 1: invert B and force the carry-in when the operands are captured.
`ifdef SERIAL_ADDSUB_SUB_EN
    assign w_b_cap   = sub_i ? ~b_i : b_i;
    assign w_cin_cap = sub_i | cin_i;
`else
    assign w_b_cap   = b_i;
    assign w_cin_cap = cin_i;
`endif

    assign w_start_ok = start_i & ~abort_i;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c        = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_a     <= a_i;
                        r_b     <= w_b_cap;
                        r_cin   <= w_cin_cap;
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= '0;
                        r_c     <= r_cin;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_a   <= r_a >> 1;
                        r_b   <= r_b >> 1;
                        r_c   <= w_c;
                        r_res <= w_res_next;
                        r_cnt <= r_cnt + CW'(1);
                        // Final bit: r_c is the carry into the MSB, w_c the carry out of it.
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_sum   <= w_res_next;
                            r_cout  <= w_c;
                            r_ovf   <= r_c ^ w_c;
                        end
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_a     <= a_i;
                        r_b     <= w_b_cap;
                        r_cin   <= w_cin_cap;
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign sum_o   = r_sum;
    assign cout_o  = r_cout;
    assign ovf_o   = r_ovf;
    assign state_o = r_state;

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Self-checking bench for serial_addsub_engine (WIDTH=8): directed cases plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_serial_addsub_engine;

    localparam int W = 8;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    serial_addsub_engine #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .start_i  (start),
        .abort_i  (abort),
        .a_i      (a),
        .b_i      (b),
        .cin_i    (cin),
`ifdef SERIAL_ADDSUB_SUB_EN
        .sub_i    (sub),
`endif
        .busy_o   (busy),
        .done_o   (done),
        .sum_o    (sum),
        .cout_o   (cout),
        .ovf_o    (ovf),
        .state_o  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow from the signed result range.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] es, output logic eco, output logic eov);
        int ua, ub, t, sa, sb, r;
        ua = int'(ma);
        ub = msub ? (255 - int'(mb)) : int'(mb);
        t  = ua + ub + (msub ? 1 : int'(mcin));
        es  = W'(t);
        eco = t[8];
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (int'(mb) > 127) ? int'(mb) - 256 : int'(mb);
        r  = msub ? (sa - sb) : (sa + sb + int'(mcin));
        eov = (r > 127) || (r < -128);
    endfunction

    // Called at a negedge: request, let it be accepted, then wait (bounded) for done_o.
    // n = edges from acceptance (inclusive) to done, bc = cycles with busy_o high.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub,
                          output int n, output int bc);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        bc = 0;
        while (n < 40 && done !== 1'b1) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tcin, input logic tsub, input int n, input int bc);
        logic [W-1:0] es;
        logic eco, eov;
        model(ta, tb, tcin, tsub, es, eco, eov);
        $display("op %s: a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d busy=%0d",
                 tag, ta, tb, tcin, tsub, sum, cout, ovf, n, bc);
        chk({tag, ".done"}, 64'(done), 64'(1));
        chk({tag, ".latency"}, 64'(n), 64'(W + 2));
        chk({tag, ".busy_cycles"}, 64'(bc), 64'(W + 1));
        chk({tag, ".sum"}, 64'(sum), 64'(es));
        chk({tag, ".cout"}, 64'(cout), 64'(eco));
        chk({tag, ".ovf"}, 64'(ovf), 64'(eov));
    endtask

    initial begin
        int n, bc, dcnt;
        logic [W-1:0] ra, rb;
        logic rcin, rsub;

        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("reset.state", 64'(state), 64'(0));
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.sum", 64'(sum), 64'(0));
        chk("reset.cout_ovf", 64'({cout, ovf}), 64'(0));
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Basic add; done lasts one cycle and the block returns to IDLE
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, n, bc);
        check_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, n, bc);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("idle_after_done", 64'(state), 64'(0));

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, n, bc);
        check_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, n, bc);
        @(negedge clk);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, n, bc);
        check_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, n, bc);
        @(negedge clk);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, n, bc);
        check_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, n, bc);
        @(negedge clk);
`ifdef SERIAL_ADDSUB_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, n, bc);
        check_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, n, bc);
        @(negedge clk);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, n, bc);
        check_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, n, bc);
        @(negedge clk);
`endif

        // Establish prior result 0x10, then abort on the 4th SHIFT cycle
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, n, bc);
        check_op("pre_abort", 8'h0F, 8'h01, 1'b0, 1'b0, n, bc);
        @(negedge clk);
        a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort.load_state", 64'(state), 64'(1));
        repeat (4) @(negedge clk);
        chk("abort.shift_state", 64'(state), 64'(2));
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        $display("abort: state=%0d busy=%0d done=%0d sum=%02h", state, busy, done, sum);
        chk("abort.state", 64'(state), 64'(0));
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.sum_held", 64'(sum), 64'(8'h10));
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (done === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk("abort.no_done", 64'(dcnt), 64'(0));

        // Back-to-back: start held in DONE with fresh operands
        run_op(8'h12, 8'h34, 1'b1, 1'b0, n, bc);
        check_op("b2b_first", 8'h12, 8'h34, 1'b1, 1'b0, n, bc);
        run_op(8'hA5, 8'h6C, 1'b0, 1'b0, n, bc);
        check_op("b2b_second", 8'hA5, 8'h6C, 1'b0, 1'b0, n, bc);
        @(negedge clk);

        // Asynchronous reset in the middle of SHIFT
        a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        $display("async reset: state=%0d busy=%0d done=%0d sum=%02h cout=%0d ovf=%0d",
                 state, busy, done, sum, cout, ovf);
        chk("areset.state", 64'(state), 64'(0));
        chk("areset.busy_done", 64'({busy, done}), 64'(0));
        chk("areset.sum", 64'(sum), 64'(0));
        chk("areset.cout_ovf", 64'({cout, ovf}), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, n, bc);
        check_op("post_reset", 8'h0F, 8'h01, 1'b0, 1'b0, n, bc);
        @(negedge clk);

        // Randomized operations, some launched back-to-back from DONE
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rcin = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDSUB_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            run_op(ra, rb, rcin, rsub, n, bc);
            check_op($sformatf("rand%0d", i), ra, rb, rcin, rsub, n, bc);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
